// File: rtl/seg_mem_pkg.sv
// Shared types and defaults for the segmented memory read path.
// The select codes match the segment register file write selector.
package seg_mem_pkg;

    localparam int ADDR_W_DEF  = 20;
    localparam int TIMEOUT_DEF = 15;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_READ,
        ST_RESP
    } state_t;

    typedef enum logic [1:0] {
        SEG_CS = 2'b00,
        SEG_DS = 2'b01,
        SEG_SS = 2'b10,
        SEG_ES = 2'b11
    } seg_sel_t;

endpackage

// File: rtl/phys_addr_calc.sv
// Real-mode style physical address: (segment * 16 + offset) mod 2^ADDR_W.
// Purely combinational so the fetch unit can reuse it unchanged.
module phys_addr_calc
    import seg_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic [7:0]        seg,
    input  logic [15:0]       offset,
    output logic [ADDR_W-1:0] addr
);

    // Wide enough to hold the 17-bit carry before reducing to ADDR_W.
    localparam int SUM_W = (ADDR_W > 17) ? ADDR_W : 17;

    logic [SUM_W-1:0] sum;

    assign sum  = SUM_W'({seg, 4'b0000}) + SUM_W'(offset);
    assign addr = sum[ADDR_W-1:0];

endmodule

// File: rtl/seg_mem_reader.sv
// Turns (segment select, offset) read requests into byte cycles on an 8-bit bus.
// Word reads are little-endian, two byte cycles, with a per-byte wait timeout.
module seg_mem_reader
    import seg_mem_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        CS,
    input  logic [7:0]        DS,
    input  logic [7:0]        SS,
    input  logic [7:0]        ES,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_seg_sel,
    input  logic [15:0]       req_offset,
    input  logic              req_word,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic              mem_ready,
    input  logic [7:0]        mem_rdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [15:0]       rsp_data,
    output logic              rsp_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t           state, state_next;
    logic [7:0]       seg_sel_val;
    logic [7:0]       seg_snap;
    logic [15:0]      off_cur;
    logic             word_q;
    logic             byte_idx;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_inc;

    always_comb begin
        seg_sel_val = CS;
        case (req_seg_sel)
            SEG_CS: seg_sel_val = CS;
            SEG_DS: seg_sel_val = DS;
            SEG_SS: seg_sel_val = SS;
            SEG_ES: seg_sel_val = ES;
            default: seg_sel_val = CS;
        endcase
    end

    assign wait_inc = wait_cnt + CNT_W'(1);

    // The snapshot only changes at accept and offset only between bytes,
    // so the address is stable through ADDR and READ without its own register.
    phys_addr_calc #(.ADDR_W(ADDR_W)) u_phys (
        .seg    (seg_snap),
        .offset (off_cur),
        .addr   (mem_addr)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, including the segment inputs at accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (req_valid) state_next = ST_ADDR;
            ST_ADDR: state_next = ST_READ;
            ST_READ: begin
                if (mem_ready) begin
                    if (word_q && !byte_idx) state_next = ST_ADDR;
                    else                     state_next = ST_RESP;
                end else if (wait_inc == CNT_W'(TIMEOUT)) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: if (rsp_ready) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == ST_IDLE);
        mem_rd    = (state == ST_READ);
        rsp_valid = (state == ST_RESP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_snap <= '0;
            off_cur  <= '0;
            word_q   <= 1'b0;
            byte_idx <= 1'b0;
            wait_cnt <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        seg_snap <= seg_sel_val;
                        off_cur  <= req_offset;
                        word_q   <= req_word;
                        byte_idx <= 1'b0;
                        rsp_data <= '0;
                        rsp_err  <= 1'b0;
                    end
                end
                ST_ADDR: wait_cnt <= '0;
                ST_READ: begin
                    if (mem_ready) begin
                        if (byte_idx) rsp_data[15:8] <= mem_rdata;
                        else          rsp_data[7:0]  <= mem_rdata;
                        if (word_q && !byte_idx) begin
                            // 16-bit wrap keeps the second byte inside the segment.
                            off_cur  <= off_cur + 16'd1;
                            byte_idx <= 1'b1;
                        end
                    end else begin
                        wait_cnt <= wait_inc;
                        if (wait_inc == CNT_W'(TIMEOUT)) rsp_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seg_mem_reader.sv
// Directed bench for seg_mem_reader: byte/word reads, wait states, wrap,
// segment snapshot, timeout, backpressure and asynchronous reset.
module tb_seg_mem_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  CS, DS, SS, ES;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_seg_sel;
    logic [15:0] req_offset;
    logic        req_word;
    logic [19:0] mem_addr;
    logic        mem_rd;
    logic        mem_ready;
    logic [7:0]  mem_rdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic        rsp_err;

    int errors = 0;
    int checks = 0;

    int          lat, rd_cyc;
    logic [19:0] a0, a1;

    seg_mem_reader #(.ADDR_W(20), .TIMEOUT(15)) dut (
        .clk         (clk),
        .rst         (rst),
        .CS          (CS),
        .DS          (DS),
        .SS          (SS),
        .ES          (ES),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_seg_sel (req_seg_sel),
        .req_offset  (req_offset),
        .req_word    (req_word),
        .mem_addr    (mem_addr),
        .mem_rd      (mem_rd),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_err     (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issues one request and plays memory until rsp_valid (bounded).
    // lat counts the sample after the accept edge as cycle 1.
    task automatic do_read(input logic [1:0] sel, input logic [15:0] off, input logic word,
                           input int w0, input int w1, input logic [7:0] b0, input logic [7:0] b1,
                           input logic cs_wr, input logic [7:0] cs_val,
                           output int lat_o, output int rd_o,
                           output logic [19:0] a0_o, output logic [19:0] a1_o);
        int bi = 0;
        int wc = 0;
        a0_o = '0;
        a1_o = '0;
        rd_o = 0;
        req_valid   = 1'b1;
        req_seg_sel = sel;
        req_offset  = off;
        req_word    = word;
        check("accept_req_ready", {31'd0, req_ready}, 32'd1);
        tick;
        req_valid = 1'b0;
        if (cs_wr) CS = cs_val;
        lat_o = 1;
        while (!rsp_valid && lat_o < 60) begin
            // Outside READ, drive a ready with garbage data that must be ignored.
            mem_ready = 1'b1;
            mem_rdata = 8'hEE;
            if (mem_rd) begin
                rd_o++;
                if (wc == 0) begin
                    if (bi == 0) a0_o = mem_addr;
                    else         a1_o = mem_addr;
                end
                if (wc < ((bi == 0) ? w0 : w1)) begin
                    mem_ready = 1'b0;
                    wc++;
                end else begin
                    mem_rdata = (bi == 0) ? b0 : b1;
                    bi++;
                    wc = 0;
                end
            end
            tick;
            lat_o++;
        end
        mem_ready = 1'b0;
    endtask

    task automatic handshake;
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
        check("hs_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("hs_req_ready", {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        CS = 8'h00; DS = 8'h12; SS = 8'h40; ES = 8'hFF;
        req_valid = 1'b0; req_seg_sel = 2'b00; req_offset = '0; req_word = 1'b0;
        mem_ready = 1'b0; mem_rdata = '0; rsp_ready = 1'b0;
        #12;
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_mem_rd",    {31'd0, mem_rd},    32'd0);
        check("rst_mem_addr",  {12'd0, mem_addr},  32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_data",  {16'd0, rsp_data},  32'd0);
        check("rst_rsp_err",   {31'd0, rsp_err},   32'd0);
        rst = 1'b0;
        tick;

        // Byte read, no wait states.
        do_read(2'b01, 16'h0034, 1'b0, 0, 0, 8'hAB, 8'h00, 1'b0, 8'h00, lat, rd_cyc, a0, a1);
        check("byte_addr",  {12'd0, a0}, 32'h00154);
        check("byte_lat",   lat, 32'd3);
        check("byte_data",  {16'd0, rsp_data}, 32'h00AB);
        check("byte_err",   {31'd0, rsp_err}, 32'd0);
        check("byte_rdy",   {31'd0, req_ready}, 32'd0);
        handshake;

        // Word read, two wait states on the low byte.
        do_read(2'b10, 16'h1000, 1'b1, 2, 0, 8'h34, 8'h12, 1'b0, 8'h00, lat, rd_cyc, a0, a1);
        check("word_addr0", {12'd0, a0}, 32'h01400);
        check("word_addr1", {12'd0, a1}, 32'h01401);
        check("word_lat",   lat, 32'd7);
        check("word_data",  {16'd0, rsp_data}, 32'h1234);
        check("word_err",   {31'd0, rsp_err}, 32'd0);

        // Backpressure: response held, new request not taken.
        req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            check("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            check("bp_rsp_data",  {16'd0, rsp_data}, 32'h1234);
            check("bp_req_ready", {31'd0, req_ready}, 32'd0);
        end
        req_valid = 1'b0;
        handshake;

        // Word read with 16-bit offset wrap at the top of the ES segment.
        do_read(2'b11, 16'hFFFF, 1'b1, 0, 0, 8'h5A, 8'hC3, 1'b0, 8'h00, lat, rd_cyc, a0, a1);
        check("wrap_addr0", {12'd0, a0}, 32'h10FEF);
        check("wrap_addr1", {12'd0, a1}, 32'h00FF0);
        check("wrap_lat",   lat, 32'd5);
        check("wrap_data",  {16'd0, rsp_data}, 32'hC35A);
        handshake;

        // Segment snapshot: CS rewritten right at the accept edge.
        CS = 8'h10;
        do_read(2'b00, 16'h0000, 1'b1, 0, 1, 8'h01, 8'h02, 1'b1, 8'h20, lat, rd_cyc, a0, a1);
        check("snap_addr0", {12'd0, a0}, 32'h00100);
        check("snap_addr1", {12'd0, a1}, 32'h00101);
        check("snap_lat",   lat, 32'd6);
        check("snap_data",  {16'd0, rsp_data}, 32'h0201);
        handshake;

        // Timeout on a byte read: memory never ready.
        do_read(2'b01, 16'h0001, 1'b0, 99, 0, 8'h00, 8'h00, 1'b0, 8'h00, lat, rd_cyc, a0, a1);
        check("to_rd_cycles", rd_cyc, 32'd15);
        check("to_lat",       lat, 32'd17);
        check("to_err",       {31'd0, rsp_err}, 32'd1);
        check("to_data",      {16'd0, rsp_data}, 32'h0000);
        check("to_addr",      {12'd0, a0}, 32'h00121);
        handshake;

        // Timeout on the high byte of a word keeps the low byte, high byte zero.
        do_read(2'b01, 16'h0002, 1'b1, 0, 99, 8'h77, 8'h00, 1'b0, 8'h00, lat, rd_cyc, a0, a1);
        check("to2_rd_cycles", rd_cyc, 32'd16);
        check("to2_err",       {31'd0, rsp_err}, 32'd1);
        check("to2_data",      {16'd0, rsp_data}, 32'h0077);
        handshake;

        // Asynchronous reset during READ aborts with no response.
        req_valid = 1'b1; req_seg_sel = 2'b01; req_offset = 16'h0020; req_word = 1'b1;
        tick;
        req_valid = 1'b0;
        mem_ready = 1'b0;
        tick;
        check("rstmid_in_read", {31'd0, mem_rd}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rstmid_mem_rd",    {31'd0, mem_rd},    32'd0);
        check("rstmid_req_ready", {31'd0, req_ready}, 32'd1);
        check("rstmid_mem_addr",  {12'd0, mem_addr},  32'd0);
        check("rstmid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rstmid_rsp_data",  {16'd0, rsp_data},  32'd0);
        check("rstmid_rsp_err",   {31'd0, rsp_err},   32'd0);
        #2 rst = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = 8'h99;
        for (int i = 0; i < 3; i++) begin
            tick;
            check("post_rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
            check("post_rst_idle",   {31'd0, req_ready}, 32'd1);
        end
        mem_ready = 1'b0;

        // Recovery: byte read with one wait state.
        do_read(2'b01, 16'h0034, 1'b0, 1, 0, 8'h5C, 8'h00, 1'b0, 8'h00, lat, rd_cyc, a0, a1);
        check("rec_addr", {12'd0, a0}, 32'h00154);
        check("rec_lat",  lat, 32'd4);
        check("rec_data", {16'd0, rsp_data}, 32'h005C);
        handshake;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
